// File: rtl/logic_sweep_pkg.sv
// Shared types and the reference gate function for the logic sweep generator.
// Also used by the bench model so both sides agree on operator encoding.
package logic_sweep_pkg;

    localparam int MAX_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    // Callers truncate the result to their own operand width.
    function automatic logic [MAX_WIDTH-1:0] op_apply(
        input op_e                  op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_sweep_gen_if.sv
// Control and observation bundle of the logic sweep generator.
// The master side drives start/op_sel; the slave (generator) drives the rest.
interface logic_sweep_gen_if #(
    parameter int WIDTH = 1
);
    logic                 start;
    logic [1:0]           op_sel;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     x;
    logic                 valid;
    logic [2*WIDTH-1:0]   vec_idx;
    logic                 busy;
    logic                 done;

    modport master (
        output start, op_sel,
        input  a, b, x, valid, vec_idx, busy, done
    );

    modport slave (
        input  start, op_sel,
        output a, b, x, valid, vec_idx, busy, done
    );
endinterface

// File: rtl/logic_op_unit.sv
// Purely combinational WIDTH-bit gate: AND / OR / XOR / NAND selected by op.
module logic_op_unit
    import logic_sweep_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = (op == OP_AND) ? (a[gi] & b[gi]) :
                           (op == OP_OR)  ? (a[gi] | b[gi]) :
                           (op == OP_XOR) ? (a[gi] ^ b[gi]) :
                                            ~(a[gi] & b[gi]);
        end
    endgenerate
endmodule

// File: rtl/logic_sweep_gen.sv
// Sweeps every {b,a} operand pair through a selectable gate, holding each for HOLD cycles.
// Define LOGIC_SWEEP_LOOP_EN for continuous looping with start acting as a stop request.
module logic_sweep_gen
    import logic_sweep_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int HOLD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_sweep_gen_if.slave sw
);
    localparam int IDX_W = 2 * WIDTH;
    localparam int HC_W  = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = {IDX_W{1'b1}};

    state_e             state_reg;
    state_e             state_next;
    op_e                op_reg;
    logic [HC_W-1:0]    hold_cnt_reg;
    logic [IDX_W-1:0]   vec_idx_reg;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   gate_y;
    logic               valid_reg;
    logic               accept;
    logic               hold_end;
    logic               finish;

    assign accept   = (state_reg != RUN) && sw.start;
    assign hold_end = (state_reg == RUN) && (hold_cnt_reg == HOLD_LAST);

`ifdef LOGIC_SWEEP_LOOP_EN
    logic stop_reg;

    // A stop request seen at any point of the hold ends the sweep after that vector.
    assign finish = hold_end && (stop_reg || sw.start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_reg <= 1'b0;
        end else if (accept) begin
            stop_reg <= 1'b0;
        end else if (state_reg == RUN && sw.start) begin
            stop_reg <= 1'b1;
        end
    end
`else
    assign finish = hold_end && (vec_idx_reg == IDX_MAX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (sw.start) state_next = RUN;
            RUN:        if (finish)   state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        sw.busy = (state_reg == RUN);
        sw.done = (state_reg == DONE);
    end

    logic_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .op (op_reg),
        .a  (vec_idx_reg[WIDTH-1:0]),
        .b  (vec_idx_reg[IDX_W-1:WIDTH]),
        .y  (gate_y)
    );

    // x follows a/b by one cycle; valid marks the first cycle x reflects a new vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= OP_AND;
            hold_cnt_reg <= '0;
            vec_idx_reg  <= '0;
            x_reg        <= '0;
            valid_reg    <= 1'b0;
        end else begin
            valid_reg <= (state_reg == RUN) && (hold_cnt_reg == '0);
            if (accept) begin
                op_reg       <= op_e'(sw.op_sel);
                hold_cnt_reg <= '0;
                vec_idx_reg  <= '0;
            end else if (state_reg == RUN) begin
                x_reg <= gate_y;
                if (hold_end) begin
                    hold_cnt_reg <= '0;
                    if (!finish) begin
                        vec_idx_reg <= vec_idx_reg + IDX_W'(1);
                    end
                end else begin
                    hold_cnt_reg <= hold_cnt_reg + HC_W'(1);
                end
            end
        end
    end

    assign sw.a       = vec_idx_reg[WIDTH-1:0];
    assign sw.b       = vec_idx_reg[IDX_W-1:WIDTH];
    assign sw.x       = x_reg;
    assign sw.valid   = valid_reg;
    assign sw.vec_idx = vec_idx_reg;

endmodule

// File: tb/tb_logic_sweep_gen.sv
// Self-checking bench: two generator instances (WIDTH=1/HOLD=2 and WIDTH=2/HOLD=3)
// checked through per-instance scoreboards fed from a vector table.
module tb_logic_sweep_gen;
    import logic_sweep_pkg::*;

    typedef struct packed {
        logic [3:0] idx;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] x;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_sweep_gen_if #(.WIDTH(1)) if1 ();
    logic_sweep_gen_if #(.WIDTH(2)) if2 ();

    logic_sweep_gen #(.WIDTH(1), .HOLD(2)) u1 (.clk(clk), .rst_n(rst_n), .sw(if1.slave));
    logic_sweep_gen #(.WIDTH(2), .HOLD(3)) u2 (.clk(clk), .rst_n(rst_n), .sw(if2.slave));

    int checks = 0;
    int failures = 0;
    int v1_cnt = 0;
    int v2_cnt = 0;
    vec_t q1[$];
    vec_t q2[$];
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int idx, input int a, input int b, input int x);
        vec_t v;
        v.idx = 4'(idx);
        v.a   = 2'(a);
        v.b   = 2'(b);
        v.x   = 2'(x);
        return v;
    endfunction

    // Scoreboards: every valid pulse pops one expected vector.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n && if1.valid === 1'b1) begin
            v1_cnt++;
            if (q1.size() == 0) check("u1_unexpected_valid", 1, 0);
            else begin
                e = q1.pop_front();
                check($sformatf("u1_vec%0d", e.idx), int'({if1.vec_idx, if1.a, if1.b, if1.x}),
                      int'({e.idx[1:0], e.a[0], e.b[0], e.x[0]}));
            end
        end
        if (rst_n && if2.valid === 1'b1) begin
            v2_cnt++;
            if (q2.size() == 0) check("u2_unexpected_valid", 1, 0);
            else begin
                e = q2.pop_front();
                check($sformatf("u2_vec%0d", e.idx), int'({if2.vec_idx, if2.a, if2.b, if2.x}),
                      int'({e.idx, e.a, e.b, e.x}));
            end
        end
    end

    task automatic sweep1(input logic [1:0] op, input int base, input bit scramble, input string tag);
        int v0;
        int cyc;
        for (int i = 0; i < 4; i++) q1.push_back(tbl[base + i]);
        @(negedge clk);
        if1.op_sel = op;
        if1.start  = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        v0  = v1_cnt;
        cyc = 0;
        while (if1.done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (scramble) if1.op_sel = 2'($urandom);
        end
        check({tag, "_cycles_to_done"}, cyc, 8);
        check({tag, "_valid_pulses"}, v1_cnt - v0, 4);
        check({tag, "_queue_left"}, q1.size(), 0);
    endtask

    task automatic sweep2(input string tag);
        int v0;
        int cyc;
        bit saw9;
        logic [7:0] r;
        for (int i = 0; i < 16; i++) begin
            r = op_apply(OP_OR, 8'(i % 4), 8'(i / 4));
            q2.push_back(mk(i, i % 4, i / 4, int'(r[1:0])));
        end
        @(negedge clk);
        if2.op_sel = 2'd1;
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        v0   = v2_cnt;
        cyc  = 0;
        saw9 = 1'b0;
        while (if2.done !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (if2.valid === 1'b1 && if2.vec_idx == 4'd9) begin
                saw9 = 1'b1;
                check({tag, "_vec9_a"}, int'(if2.a), 1);
                check({tag, "_vec9_b"}, int'(if2.b), 2);
                check({tag, "_vec9_x"}, int'(if2.x), 3);
            end
        end
        check({tag, "_busy_cycles"}, cyc, 48);
        check({tag, "_valid_pulses"}, v2_cnt - v0, 16);
        check({tag, "_saw_vec9"}, int'(saw9), 1);
        check({tag, "_queue_left"}, q2.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        // AND, XOR, NAND truth tables in sweep order (a fastest).
        tbl[0]  = mk(0, 0, 0, 0); tbl[1]  = mk(1, 1, 0, 0); tbl[2]  = mk(2, 0, 1, 0); tbl[3]  = mk(3, 1, 1, 1);
        tbl[4]  = mk(0, 0, 0, 0); tbl[5]  = mk(1, 1, 0, 1); tbl[6]  = mk(2, 0, 1, 1); tbl[7]  = mk(3, 1, 1, 0);
        tbl[8]  = mk(0, 0, 0, 1); tbl[9]  = mk(1, 1, 0, 1); tbl[10] = mk(2, 0, 1, 1); tbl[11] = mk(3, 1, 1, 0);

        if1.start = 1'b0; if1.op_sel = 2'd0;
        if2.start = 1'b0; if2.op_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_u1_outputs", int'({if1.a, if1.b, if1.x, if1.vec_idx, if1.valid, if1.busy, if1.done}), 0);
        check("reset_u2_outputs", int'({if2.a, if2.b, if2.x, if2.vec_idx, if2.valid, if2.busy, if2.done}), 0);
        rst_n = 1'b1;

`ifndef LOGIC_SWEEP_LOOP_EN
        sweep1(2'd0, 0, 1'b0, "and");
        repeat (3) @(posedge clk);
        #1;
        check("and_done_held", int'({if1.done, if1.busy}), 2);
        check("and_abx_held", int'({if1.a, if1.b, if1.x}), 7);
        sweep1(2'd2, 4, 1'b1, "xor");
        sweep1(2'd3, 8, 1'b1, "nand");

        // start held through a whole sweep, then into DONE.
        for (int i = 0; i < 4; i++) q1.push_back(tbl[i]);
        for (int i = 0; i < 4; i++) q1.push_back(tbl[i]);
        @(negedge clk);
        if1.op_sel = 2'd0;
        if1.start  = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (if1.done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("held_start_cycles_to_done", cyc, 8);
        @(posedge clk); #1;
        check("held_start_restart", int'({if1.busy, if1.done, if1.vec_idx}), 8);
        if1.start = 1'b0;
        cyc = 0;
        while (if1.done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("restart_cycles_to_done", cyc, 8);
        check("restart_queue_left", q1.size(), 0);

        sweep2("or");

        // Asynchronous reset in the middle of vector 5's hold.
        for (int i = 0; i < 6; i++) q2.push_back(mk(i, i % 4, i / 4, (i % 4) | (i / 4)));
        @(negedge clk);
        if2.op_sel = 2'd1;
        if2.start  = 1'b1;
        @(posedge clk); #1;
        if2.start = 1'b0;
        cyc = 0;
        while (if2.vec_idx != 4'd5 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("midrst_reached_vec5", int'(if2.vec_idx), 5);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_u2_outputs", int'({if2.a, if2.b, if2.x, if2.vec_idx, if2.valid, if2.busy, if2.done}), 0);
        check("midrst_u1_done", int'({if1.busy, if1.done}), 0);
        check("midrst_queue_left", q2.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep2("or_after_rst");
`else
        for (int i = 0; i < 4; i++) q1.push_back(tbl[i]);
        for (int i = 0; i < 3; i++) q1.push_back(tbl[i]);
        @(negedge clk);
        if1.op_sel = 2'd0;
        if1.start  = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        cyc = 0;
        while (if1.vec_idx != 2'd3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("loop_reached_vec3", int'(if1.vec_idx), 3);
        while (if1.vec_idx == 2'd3 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("loop_wrap_to_0", int'({if1.done, if1.vec_idx}), 0);
        while (if1.vec_idx != 2'd2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("loop_reached_vec2", int'(if1.vec_idx), 2);
        if1.start = 1'b1;
        @(posedge clk); #1;
        if1.start = 1'b0;
        cyc = 0;
        while (if1.done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("loop_stop_cycles", cyc, 1);
        check("loop_stop_vec", int'({if1.vec_idx, if1.a, if1.b}), 9);
        check("loop_queue_left", q1.size(), 0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
